// File: rtl/ice81_mem_pkg.sv
// Shared definitions for the ice81 memory subsystem: arbiter states, requester ids
// and default bus widths.
package ice81_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: fixed CPU priority, except that DMA wins a tie
// once the CPU has used up its streak allowance.
module arb_pick
    import ice81_mem_pkg::*;
#(
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic       c_req,
    input  logic       d_req,
    input  logic [3:0] streak,
    output logic       win_id,
    output logic       win_valid
);

    logic streak_full;

    assign streak_full = (streak == 4'(MAX_CPU_STREAK));

    always_comb begin
        win_valid = c_req | d_req;
        win_id    = REQ_CPU;
        if (c_req && !(d_req && streak_full)) begin
            win_id = REQ_CPU;
        end else if (d_req) begin
            win_id = REQ_DMA;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of the single-port 32K SPRAM.
// Optional CPU write-protect window is enabled by defining SPRAM_WP_EN.
//
// state | meaning
// IDLE  | sample requests, latch winner's access into ram_* registers
// ISSUE | ram_ce high, SPRAM samples at end of cycle
// WAIT  | ram_dout valid, captured into winner's rdata on reads
// DONE  | one-cycle ack to the winner
module spram_arbiter
    import ice81_mem_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int MAX_CPU_STREAK = 4
`ifdef SPRAM_WP_EN
    ,
    parameter logic [ADDR_W-1:0] WP_BASE  = '0,
    parameter logic [ADDR_W-1:0] WP_LIMIT = ADDR_W'(15'h03FF)
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
`ifdef SPRAM_WP_EN
    output logic              wp_hit,
`endif
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_t state;
    logic [3:0] streak;
    logic       win_id;
    logic       acc_we;
    logic       pick_id;
    logic       pick_valid;
    logic       c_prot;

    arb_pick #(
        .MAX_CPU_STREAK(MAX_CPU_STREAK)
    ) u_pick (
        .c_req    (c_req),
        .d_req    (d_req),
        .streak   (streak),
        .win_id   (pick_id),
        .win_valid(pick_valid)
    );

`ifdef SPRAM_WP_EN
    logic wp_pend;
    // Offset compare keeps the window check correct for any base, including 0.
    assign c_prot = c_we &&
                    ((c_addr - WP_BASE) <= (WP_LIMIT - WP_BASE));
`else
    assign c_prot = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            streak  <= '0;
            win_id  <= REQ_CPU;
            acc_we  <= 1'b0;
            c_ack   <= 1'b0;
            d_ack   <= 1'b0;
            c_rdata <= '0;
            d_rdata <= '0;
            ram_ce  <= 1'b0;
            ram_we  <= 1'b0;
            ram_a   <= '0;
            ram_din <= '0;
`ifdef SPRAM_WP_EN
            wp_pend <= 1'b0;
            wp_hit  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!d_req || (pick_valid && pick_id == REQ_DMA)) begin
                        streak <= '0;
                    end else if (pick_valid && streak < 4'(MAX_CPU_STREAK)) begin
                        streak <= streak + 4'd1;
                    end
                    if (pick_valid) begin
                        win_id <= pick_id;
                        ram_ce <= 1'b1;
                        state  <= ISSUE;
                        if (pick_id == REQ_CPU) begin
                            ram_a   <= c_addr;
                            ram_din <= c_wdata;
                            acc_we  <= c_we;
                            ram_we  <= c_we && !c_prot;
`ifdef SPRAM_WP_EN
                            wp_pend <= c_prot;
`endif
                        end else begin
                            ram_a   <= d_addr;
                            ram_din <= d_wdata;
                            acc_we  <= d_we;
                            ram_we  <= d_we;
`ifdef SPRAM_WP_EN
                            wp_pend <= 1'b0;
`endif
                        end
                    end
                end
                ISSUE: begin
                    ram_ce <= 1'b0;
                    ram_we <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (!acc_we) begin
                        if (win_id == REQ_CPU) c_rdata <= ram_dout;
                        else                   d_rdata <= ram_dout;
                    end
                    c_ack <= (win_id == REQ_CPU);
                    d_ack <= (win_id == REQ_DMA);
`ifdef SPRAM_WP_EN
                    wp_hit <= wp_pend;
`endif
                    state <= DONE;
                end
                DONE: begin
                    c_ack <= 1'b0;
                    d_ack <= 1'b0;
`ifdef SPRAM_WP_EN
                    wp_hit <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter with a behavioural registered-read SPRAM.
module tb_spram_arbiter;
    import ice81_mem_pkg::*;

    localparam int AW = 15;
    localparam int DW = 8;
`ifdef SPRAM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_ack, d_ack;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;
`ifdef SPRAM_WP_EN
    logic          wp_hit;
`endif

    spram_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_ack   (c_ack),
        .c_rdata (c_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
`ifdef SPRAM_WP_EN
        .wp_hit  (wp_hit),
`endif
        .ram_ce  (ram_ce),
        .ram_we  (ram_we),
        .ram_a   (ram_a),
        .ram_din (ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [0:32767];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_a] <= ram_din;
            else        ram_dout   <= mem[ram_a];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic          we;
        logic          wp;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           c_sb[$];
    sb_t           d_sb[$];
    byte           order_q[$];
    bit            order_en = 1'b0;
    logic [DW-1:0] ref_mem [0:32767];
    logic [DW-1:0] last_c_rd = '0;
    logic [DW-1:0] last_d_rd = '0;

    function automatic logic cpu_prot(input logic we, input logic [AW-1:0] addr);
        return WP_ON && we && (addr <= 15'h03FF);
    endfunction

    sb_t e_mon;
    always @(negedge clk) begin
        if (rst_n) begin
            if (c_ack) begin
                check("ack_exclusive", {31'd0, d_ack}, 32'd0);
                if (c_sb.size() == 0) begin
                    check("c_ack_unexpected", 32'd1, 32'd0);
                end else begin
                    e_mon = c_sb.pop_front();
                    if (!e_mon.we) last_c_rd = e_mon.data;
                    check("c_rdata", {24'd0, c_rdata}, {24'd0, last_c_rd});
`ifdef SPRAM_WP_EN
                    check("wp_hit", {31'd0, wp_hit}, {31'd0, e_mon.wp});
`endif
                    check("d_rdata_hold", {24'd0, d_rdata}, {24'd0, last_d_rd});
                end
            end
            if (d_ack) begin
                if (d_sb.size() == 0) begin
                    check("d_ack_unexpected", 32'd1, 32'd0);
                end else begin
                    e_mon = d_sb.pop_front();
                    if (!e_mon.we) last_d_rd = e_mon.data;
                    check("d_rdata", {24'd0, d_rdata}, {24'd0, last_d_rd});
                    check("c_rdata_hold", {24'd0, c_rdata}, {24'd0, last_c_rd});
                end
            end
            if (order_en && (c_ack || d_ack)) begin
                if (order_q.size() == 0) check("order_extra", 32'd1, 32'd0);
                else check("grant_order", c_ack ? 32'h43 : 32'h44, 32'(order_q.pop_front()));
            end
        end
    end

    // One complete request/ack handshake on either port; lat enables cycle-exact checks.
    task automatic access(input bit dma, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input bit lat, input bit scramble);
        sb_t  e;
        int   start;
        bit   done;
        logic prot;
        prot   = dma ? 1'b0 : cpu_prot(we, addr);
        e.we   = we;
        e.wp   = prot;
        e.addr = addr;
        e.data = we ? wdata : ref_mem[addr];
        if (we && !prot) ref_mem[addr] = wdata;
        if (dma) begin
            d_sb.push_back(e);
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            c_sb.push_back(e);
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
        end
        start = cyc;
        done  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (lat && cyc - start == 1) begin
                check("issue_ce", {31'd0, ram_ce}, 32'd1);
                check("issue_we", {31'd0, ram_we}, {31'd0, we && !prot});
                check("issue_a", {17'd0, ram_a}, {17'd0, addr});
                if (we) check("issue_din", {24'd0, ram_din}, {24'd0, wdata});
            end
            if (lat && cyc - start == 2) check("wait_ce", {31'd0, ram_ce}, 32'd0);
            if (scramble && cyc - start == 2) begin
                if (dma) begin d_addr = ~addr; d_wdata = ~wdata; end
                else     begin c_addr = ~addr; c_wdata = ~wdata; end
            end
            if (dma ? d_ack : c_ack) begin
                done = 1'b1;
                if (lat) check("ack_latency", 32'(cyc - start), 32'd3);
            end
        end
        if (!done) check(dma ? "d_ack_timeout" : "c_ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (dma) d_req = 1'b0;
        else     c_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c_ack", {31'd0, c_ack}, 32'd0);
        check("rst_d_ack", {31'd0, d_ack}, 32'd0);
        check("rst_ram_ce", {31'd0, ram_ce}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_a", {17'd0, ram_a}, 32'd0);
        check("rst_c_rdata", {24'd0, c_rdata}, 32'd0);
        check("rst_d_rdata", {24'd0, d_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        access(1'b0, 1'b1, 15'h1234, 8'hA5, 1'b1, 1'b0);
        access(1'b0, 1'b0, 15'h1234, 8'h00, 1'b1, 1'b0);

        access(1'b1, 1'b1, 15'h7FFF, 8'h3C, 1'b1, 1'b0);
        access(1'b1, 1'b0, 15'h7FFF, 8'h00, 1'b1, 1'b0);
        check("c_rdata_unchanged", {24'd0, c_rdata}, 32'hA5);
        access(1'b1, 1'b1, 15'h0000, 8'h5A, 1'b1, 1'b0);
        access(1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b0);
        access(1'b0, 1'b1, 15'h0000, 8'h66, 1'b1, 1'b0);
        access(1'b1, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b0);

        access(1'b0, 1'b1, 15'h0555, 8'h96, 1'b1, 1'b1);
        access(1'b0, 1'b0, 15'h0555, 8'h00, 1'b1, 1'b1);

        // Both ports saturated: CPU streak of 4 must yield to DMA.
        for (int i = 0; i < 2; i++) begin
            repeat (4) order_q.push_back(8'h43);
            order_q.push_back(8'h44);
        end
        order_en = 1'b1;
        fork
            for (int i = 0; i < 8; i++)
                access(1'b0, 1'b1, AW'(16'h4000 + i), DW'(i * 7 + 1), 1'b0, 1'b0);
            for (int j = 0; j < 2; j++)
                access(1'b1, 1'b1, AW'(16'h2000 + j), DW'(8'hC0 + j), 1'b0, 1'b0);
        join
        order_en = 1'b0;
        check("order_remaining", 32'(order_q.size()), 32'd0);
        access(1'b0, 1'b0, 15'h4003, 8'h00, 1'b1, 1'b0);
        access(1'b1, 1'b0, 15'h2001, 8'h00, 1'b1, 1'b0);

        // Reset during WAIT of a CPU read aborts it with no ack.
        c_req = 1'b1; c_we = 1'b0; c_addr = 15'h1234;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_c_ack", {31'd0, c_ack}, 32'd0);
        check("abort_ram_ce", {31'd0, ram_ce}, 32'd0);
        check("abort_ram_a", {17'd0, ram_a}, 32'd0);
        check("abort_ram_din", {24'd0, ram_din}, 32'd0);
        check("abort_c_rdata", {24'd0, c_rdata}, 32'd0);
        check("abort_d_rdata", {24'd0, d_rdata}, 32'd0);
        c_req = 1'b0;
        last_c_rd = '0;
        last_d_rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_ack_after_rst", {31'd0, c_ack}, 32'd0);
        end
        @(posedge clk);
        #1;
        access(1'b0, 1'b0, 15'h1234, 8'h00, 1'b1, 1'b0);

`ifdef SPRAM_WP_EN
        access(1'b1, 1'b1, 15'h0010, 8'h11, 1'b1, 1'b0);
        access(1'b0, 1'b1, 15'h0010, 8'hFF, 1'b1, 1'b0);
        access(1'b0, 1'b0, 15'h0010, 8'h00, 1'b1, 1'b0);
        access(1'b1, 1'b1, 15'h0010, 8'h77, 1'b1, 1'b0);
        access(1'b1, 1'b0, 15'h0010, 8'h00, 1'b1, 1'b0);
`endif

        repeat (4) @(negedge clk);
        check("c_sb_empty", 32'(c_sb.size()), 32'd0);
        check("d_sb_empty", 32'(d_sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
